// File: rtl/ivector_echo_pkg.sv
// ivector_echo_pkg
// Shared types and helpers for the vector echo channel.
//   ELEM_W_DEF / NUM_ELEM_DEF : default element width and element count
//   elem_t                    : one vector element
//   entry_t                   : one FIFO entry {reverse, vec}
//   reverse_elems()           : reverses element order, keeps bit order inside elements
package ivector_echo_pkg;

    localparam int ELEM_W_DEF   = 32;
    localparam int NUM_ELEM_DEF = 22;
    localparam int VEC_W_DEF    = ELEM_W_DEF * NUM_ELEM_DEF;

    typedef logic [ELEM_W_DEF-1:0] elem_t;

    typedef struct packed {
        logic                 reverse;
        logic [VEC_W_DEF-1:0] vec;
    } entry_t;

    function automatic logic [VEC_W_DEF-1:0] reverse_elems(input logic [VEC_W_DEF-1:0] v);
        logic [VEC_W_DEF-1:0] r;
        elem_t                e;
        r = {VEC_W_DEF{1'b0}};
        for (int i = 0; i < NUM_ELEM_DEF; i++) begin
            e = v[i*ELEM_W_DEF +: ELEM_W_DEF];
            r[(NUM_ELEM_DEF-1-i)*ELEM_W_DEF +: ELEM_W_DEF] = e;
        end
        return r;
    endfunction

endpackage

// File: rtl/ivector_echo_fifo.sv
// ivector_echo_fifo
// Generic registered FIFO with ENA/RDY handshakes on both sides.
// No write-through: data written at edge N is visible at the head after edge N.
// Full/empty flags depend on registered count only (no RDY->ENA path, no full bypass).
// Ports:
//   clk_i, rst_i         : clock, synchronous active-high reset
//   enq_ena_i/enq_data_i : write strobe and data; accepted when enq_rdy_o=1
//   enq_rdy_o            : not full
//   deq_ena_o/deq_data_o : head valid and head data
//   deq_rdy_i            : consumer accepts head
//   count_o              : entries held
module ivector_echo_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             enq_ena_i,
    input  logic [WIDTH-1:0] enq_data_i,
    output logic             enq_rdy_o,
    output logic             deq_ena_o,
    output logic [WIDTH-1:0] deq_data_o,
    input  logic             deq_rdy_i,
    output logic [CNT_W-1:0] count_o
);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1'b1);
    localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             enq_fire_s;
    logic             deq_fire_s;

    assign enq_rdy_o  = (count_q != CNT_FULL);
    assign deq_ena_o  = (count_q != CNT_ZERO);
    assign deq_data_o = mem_q[rd_ptr_q];
    assign count_o    = count_q;

    assign enq_fire_s = enq_ena_i & enq_rdy_o;
    assign deq_fire_s = deq_ena_o & deq_rdy_i;

    // Next-state for pointers and occupancy; DEPTH is a power of two so pointers wrap naturally
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (enq_fire_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (deq_fire_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({enq_fire_s, deq_fire_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Control state registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= PTR_ZERO;
            rd_ptr_q <= PTR_ZERO;
            count_q  <= CNT_ZERO;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is never reset; writes during reset are ignored
    always_ff @(posedge clk_i) begin
        if (enq_fire_s && !rst_i) begin
            mem_q[wr_ptr_q] <= enq_data_i;
        end
    end

endmodule

// File: rtl/ivector_echo.sv
// ivector_echo
// Vector echo channel: buffers request_say vectors in a DEPTH-entry FIFO and
// replays them on ind_heard, optionally with element order reversed per entry.
// Optional feature macro: IVECTOR_ECHO_STATS_EN adds stats_enq_count/stats_deq_count.
// Ports:
//   CLK, RST                     : clock, synchronous active-high reset
//   request_say__ENA/__RDY       : enqueue handshake (RDY = not full)
//   request_say_v, _reverse      : vector and per-entry reverse flag
//   ind_heard__ENA/__RDY         : dequeue handshake (ENA = not empty)
//   ind_heard_v                  : head vector after optional reversal
//   occupancy                    : entries held (registered)
//   stats_enq_count/deq_count    : accepted transfer counters (macro only)

// Protocol checker: enqueue strobe while full is dropped by the FIFO and flagged here
module ivector_echo_chk (
    input logic clk_i,
    input logic rst_i,
    input logic ena_i,
    input logic rdy_i
);
    // Flag writes attempted while the FIFO is full
    always_ff @(posedge clk_i) begin
        if (!rst_i && ena_i) begin
            assert (rdy_i)
            else $warning("ivector_echo: request_say__ENA while request_say__RDY=0, write dropped");
        end
    end
endmodule

module ivector_echo
    import ivector_echo_pkg::*;
#(
    parameter  int ELEM_W   = ELEM_W_DEF,
    parameter  int NUM_ELEM = NUM_ELEM_DEF,
    parameter  int DEPTH    = 4,
    localparam int VEC_W    = ELEM_W * NUM_ELEM,
    localparam int CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             request_say__ENA,
    input  logic [VEC_W-1:0] request_say_v,
    input  logic             request_say_reverse,
    output logic             request_say__RDY,
    output logic             ind_heard__ENA,
    output logic [VEC_W-1:0] ind_heard_v,
    input  logic             ind_heard__RDY,
    output logic [CNT_W-1:0] occupancy
`ifdef IVECTOR_ECHO_STATS_EN
    ,
    output logic [31:0]      stats_enq_count,
    output logic [31:0]      stats_deq_count
`endif
);

    logic [VEC_W:0]   fifo_dout_s;
    logic             head_rev_s;
    logic [VEC_W-1:0] head_vec_s;
    logic [VEC_W-1:0] rev_vec_s;

    ivector_echo_fifo #(
        .WIDTH (VEC_W + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i      (CLK),
        .rst_i      (RST),
        .enq_ena_i  (request_say__ENA),
        .enq_data_i ({request_say_reverse, request_say_v}),
        .enq_rdy_o  (request_say__RDY),
        .deq_ena_o  (ind_heard__ENA),
        .deq_data_o (fifo_dout_s),
        .deq_rdy_i  (ind_heard__RDY),
        .count_o    (occupancy)
    );

    ivector_echo_chk u_chk (
        .clk_i (CLK),
        .rst_i (RST),
        .ena_i (request_say__ENA),
        .rdy_i (request_say__RDY)
    );

    assign head_rev_s = fifo_dout_s[VEC_W];
    assign head_vec_s = fifo_dout_s[VEC_W-1:0];

    // The package helper is sized for the default geometry; other geometries use a generic swap
    if (ELEM_W == ELEM_W_DEF && NUM_ELEM == NUM_ELEM_DEF) begin : g_rev_pkg
        entry_t head_entry_s;
        assign head_entry_s = fifo_dout_s;
        assign rev_vec_s    = reverse_elems(head_entry_s.vec);
    end else begin : g_rev_gen
        for (genvar i = 0; i < NUM_ELEM; i++) begin : g_elem
            assign rev_vec_s[i*ELEM_W +: ELEM_W] = head_vec_s[(NUM_ELEM-1-i)*ELEM_W +: ELEM_W];
        end
    end

    // Head transform: pick reversed or straight view per the entry's stored flag
    always_comb begin
        ind_heard_v = head_vec_s;
        if (head_rev_s) begin
            ind_heard_v = rev_vec_s;
        end else begin
            ind_heard_v = head_vec_s;
        end
    end

`ifdef IVECTOR_ECHO_STATS_EN
    logic [31:0] enq_cnt_q;
    logic [31:0] deq_cnt_q;

    // Free-running transfer counters, wrapping at 2^32
    always_ff @(posedge CLK) begin
        if (RST) begin
            enq_cnt_q <= 32'd0;
            deq_cnt_q <= 32'd0;
        end else begin
            if (request_say__ENA && request_say__RDY) begin
                enq_cnt_q <= enq_cnt_q + 32'd1;
            end
            if (ind_heard__ENA && ind_heard__RDY) begin
                deq_cnt_q <= deq_cnt_q + 32'd1;
            end
        end
    end

    assign stats_enq_count = enq_cnt_q;
    assign stats_deq_count = deq_cnt_q;
`endif

endmodule

// File: tb/tb_ivector_echo.sv
module tb_ivector_echo;

    localparam int EW    = 32;
    localparam int NE    = 22;
    localparam int DEPTH = 4;
    localparam int VEC_W = EW * NE;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             clk;
    logic             rst;
    logic             req_ena;
    logic [VEC_W-1:0] req_v;
    logic             req_rev;
    logic             req_rdy;
    logic             ind_ena;
    logic [VEC_W-1:0] ind_v;
    logic             ind_rdy;
    logic [CNT_W-1:0] occ;
`ifdef IVECTOR_ECHO_STATS_EN
    logic [31:0]      st_enq;
    logic [31:0]      st_deq;
`endif

    int checks = 0;
    int errors = 0;
    int enq_model = 0;
    int deq_model = 0;
    logic [VEC_W-1:0] exp_q [$];

    ivector_echo #(
        .ELEM_W   (EW),
        .NUM_ELEM (NE),
        .DEPTH    (DEPTH)
    ) dut (
        .CLK                 (clk),
        .RST                 (rst),
        .request_say__ENA    (req_ena),
        .request_say_v       (req_v),
        .request_say_reverse (req_rev),
        .request_say__RDY    (req_rdy),
        .ind_heard__ENA      (ind_ena),
        .ind_heard_v         (ind_v),
        .ind_heard__RDY      (ind_rdy),
        .occupancy           (occ)
`ifdef IVECTOR_ECHO_STATS_EN
        ,
        .stats_enq_count     (st_enq),
        .stats_deq_count     (st_deq)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [VEC_W-1:0] swap_order(input logic [VEC_W-1:0] v);
        logic [VEC_W-1:0] r;
        for (int k = 0; k < NE; k++) r[(NE-1-k)*EW +: EW] = v[k*EW +: EW];
        return r;
    endfunction

    function automatic logic [VEC_W-1:0] ramp_vec();
        logic [VEC_W-1:0] r;
        for (int k = 0; k < NE; k++) r[k*EW +: EW] = 32'(k + 1);
        return r;
    endfunction

    function automatic logic [VEC_W-1:0] rand_vec();
        logic [VEC_W-1:0] r;
        for (int k = 0; k < NE; k++) r[k*EW +: EW] = $urandom();
        return r;
    endfunction

    // One clock: check handshake/occupancy against the model, pop/push scoreboard, advance.
    task automatic tick(input logic enq, input logic [VEC_W-1:0] v, input logic rev, input logic rdy);
        int sz;
        logic [VEC_W-1:0] exp_v;
        req_ena = enq;
        req_v   = v;
        req_rev = rev;
        ind_rdy = rdy;
        #1;
        sz = exp_q.size();
        checks++;
        if (occ !== CNT_W'(sz)) begin
            errors++;
            $display("FAIL occupancy: got %0d expected %0d", occ, sz);
        end
        checks++;
        if (req_rdy !== (sz < DEPTH)) begin
            errors++;
            $display("FAIL say_rdy: got %b expected %b", req_rdy, (sz < DEPTH));
        end
        checks++;
        if (ind_ena !== (sz > 0)) begin
            errors++;
            $display("FAIL heard_ena: got %b expected %b", ind_ena, (sz > 0));
        end
        if (rdy && sz > 0) begin
            exp_v = exp_q.pop_front();
            deq_model++;
            checks++;
            if (ind_v !== exp_v) begin
                errors++;
                $display("FAIL heard_v: got %h expected %h", ind_v, exp_v);
            end
        end
        if (enq && sz < DEPTH) begin
            exp_q.push_back(rev ? swap_order(v) : v);
            enq_model++;
        end
        @(posedge clk);
        #1;
        req_ena = 1'b0;
    endtask

    task automatic do_reset(input logic ena_in_reset);
        rst     = 1'b1;
        req_ena = ena_in_reset;
        req_v   = rand_vec();
        req_rev = 1'b0;
        ind_rdy = 1'b0;
        @(posedge clk);
        #1;
        rst     = 1'b0;
        req_ena = 1'b0;
        exp_q.delete();
        enq_model = 0;
        deq_model = 0;
    endtask

    task automatic check_idle(input string tag);
        checks++;
        if (req_rdy !== 1'b1 || ind_ena !== 1'b0 || occ !== 3'd0) begin
            errors++;
            $display("FAIL %s: got rdy=%b ena=%b occ=%0d expected rdy=1 ena=0 occ=0", tag, req_rdy, ind_ena, occ);
        end
`ifdef IVECTOR_ECHO_STATS_EN
        checks++;
        if (st_enq !== 32'd0 || st_deq !== 32'd0) begin
            errors++;
            $display("FAIL %s_stats: got enq=%0d deq=%0d expected 0 0", tag, st_enq, st_deq);
        end
`endif
    endtask

    task automatic test_reset();
        do_reset(1'b0);
        check_idle("reset");
    endtask

    task automatic test_single();
        logic [VEC_W-1:0] v;
        v = ramp_vec();
        tick(1'b1, v, 1'b0, 1'b1);
        checks++;
        if (ind_ena !== 1'b1 || ind_v !== v) begin
            errors++;
            $display("FAIL single_echo: got ena=%b v=%h expected ena=1 v=%h", ind_ena, ind_v, v);
        end
        tick(1'b0, v, 1'b0, 1'b1);
        checks++;
        if (occ !== 3'd0 || ind_ena !== 1'b0) begin
            errors++;
            $display("FAIL single_drain: got occ=%0d ena=%b expected 0 0", occ, ind_ena);
        end
    endtask

    task automatic test_reverse();
        logic [VEC_W-1:0] v;
        v = ramp_vec();
        tick(1'b1, v, 1'b1, 1'b0);
        checks++;
        if (ind_v[0 +: EW] !== 32'd22 || ind_v[21*EW +: EW] !== 32'd1) begin
            errors++;
            $display("FAIL reverse_elems: got e0=%0d e21=%0d expected 22 1", ind_v[0 +: EW], ind_v[21*EW +: EW]);
        end
        tick(1'b0, v, 1'b0, 1'b1);
    endtask

    task automatic test_full();
        for (int k = 0; k < DEPTH; k++) tick(1'b1, rand_vec(), 1'($urandom_range(0, 1)), 1'b0);
        checks++;
        if (occ !== 3'd4 || req_rdy !== 1'b0) begin
            errors++;
            $display("FAIL full_flags: got occ=%0d rdy=%b expected 4 0", occ, req_rdy);
        end
        // Overflow attempt is dropped
        tick(1'b1, rand_vec(), 1'b0, 1'b0);
        // Enqueue while full and dequeuing: still refused (no full bypass)
        tick(1'b1, rand_vec(), 1'b0, 1'b1);
        for (int k = 0; k < DEPTH - 1; k++) tick(1'b0, req_v, 1'b0, 1'b1);
        checks++;
        if (occ !== 3'd0 || ind_ena !== 1'b0) begin
            errors++;
            $display("FAIL full_drain: got occ=%0d ena=%b expected 0 0", occ, ind_ena);
        end
    endtask

    task automatic test_back_to_back();
        tick(1'b1, rand_vec(), 1'b0, 1'b0);
        tick(1'b1, rand_vec(), 1'b1, 1'b0);
        for (int k = 0; k < 10; k++) tick(1'b1, rand_vec(), 1'($urandom_range(0, 1)), 1'b1);
        checks++;
        if (occ !== 3'd2) begin
            errors++;
            $display("FAIL b2b_occupancy: got %0d expected 2", occ);
        end
        tick(1'b0, req_v, 1'b0, 1'b1);
        tick(1'b0, req_v, 1'b0, 1'b1);
        tick(1'b0, req_v, 1'b0, 1'b1);
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 3; k++) tick(1'b1, rand_vec(), 1'b0, 1'b0);
        do_reset(1'b1);
        check_idle("reset_mid");
        tick(1'b1, rand_vec(), 1'b1, 1'b0);
        tick(1'b0, req_v, 1'b0, 1'b1);
        tick(1'b0, req_v, 1'b0, 1'b1);
    endtask

    initial begin
        rst     = 1'b1;
        req_ena = 1'b0;
        req_v   = {VEC_W{1'b0}};
        req_rev = 1'b0;
        ind_rdy = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_reverse();
        test_full();
        test_back_to_back();
        test_reset_mid();
`ifdef IVECTOR_ECHO_STATS_EN
        checks++;
        if (st_enq !== 32'(enq_model) || st_deq !== 32'(deq_model)) begin
            errors++;
            $display("FAIL stats_final: got enq=%0d deq=%0d expected %0d %0d", st_enq, st_deq, enq_model, deq_model);
        end
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ivector_echo.md
Name: ivector_echo

Overview:
Parametrised vector echo channel: accepts a NUM_ELEM x ELEM_W vector on the request$say method, buffers it in a DEPTH-entry FIFO, and replays it on the ind$heard indication.
- Successor to the fixed 22x32, single-entry echo path.
- Adds configurable depth, a per-entry element-order reversal mode and an occupancy output.
- Sits between the host request decoder and the indication serializer.

Parameters:
ELEM_W, 32, width of one vector element in bits
NUM_ELEM, 22, elements per vector; vector width VEC_W = ELEM_W*NUM_ELEM
DEPTH, 4, FIFO entries; power of two, >=2
CNT_W, $clog2(DEPTH+1), occupancy counter width (derived, not overridable)

Ports:
CLK  input  1  clock, all state on rising edge
RST  input  1  synchronous, active-high reset
request$say__ENA  input  1  enqueue strobe; legal only while request$say__RDY=1
request$say$v  input  VEC_W  vector; element i at bits [i*ELEM_W +: ELEM_W]
request$say$reverse  input  1  sampled with ENA; 1 = replay this entry with element order reversed
request$say__RDY  output  1  FIFO not full
ind$heard__ENA  output  1  FIFO not empty; head entry valid
ind$heard$v  output  VEC_W  head vector, transformed per its stored reverse bit
ind$heard__RDY  input  1  consumer accepts; transfer when ENA&RDY
occupancy  output  CNT_W  entries currently held

Behaviour:
- Reset (RST=1 at a clock edge): rd/wr pointers=0, count=0. Outputs next cycle: request$say__RDY=1, ind$heard__ENA=0, occupancy=0. ind$heard$v is don't-care while ENA=0, but implementation drives it from RAM head (no reset of storage).
- Reset mid-operation discards all entries. Any ENA in the reset cycle is ignored.
- Enqueue: on edge with request$say__ENA=1 and __RDY=1, write {reverse, v} at wr_ptr; wr_ptr wraps modulo DEPTH.
- ENA while RDY=0 is a protocol violation. The write is dropped; an assertion fires in simulation.
- Dequeue: on edge with ind$heard__ENA=1 and ind$heard__RDY=1, rd_ptr advances modulo DEPTH.
- ind$heard__ENA does not depend on ind$heard__RDY, so there is no combinational RDY->ENA path.
- Latency: an entry written at edge N is visible on ind$heard at cycle N+1 (registered, no write-through bypass when empty).
- Full: request$say__RDY=0 when count==DEPTH, even if a dequeue occurs the same cycle. No full-bypass; RDY is a pure function of registered state.
- Simultaneous enq+deq when 0<count<DEPTH: count unchanged; both pointers advance.
- Empty: ind$heard__ENA=0; dequeue impossible.
- Count: +1 on enq only, -1 on deq only; never exceeds DEPTH or underflows. occupancy = count, registered.
- Output transform, combinational from head entry:
  - reverse=0: out element i = stored element i.
  - reverse=1: out element i = stored element NUM_ELEM-1-i.
  - Bit order within an element is never changed.
- ind$heard$v and ENA stay stable while ENA=1 and RDY=0.

Optional Feature:
Macro IVECTOR_ECHO_STATS_EN.
- Defined: adds outputs stats$enq_count[31:0] and stats$deq_count[31:0].
  - Free-running, wrap at 2^32, cleared by RST.
  - Increment on each accepted enqueue / dequeue respectively.
- Undefined: ports and counters absent; all other behaviour identical.

Decomposition:
- Package ivector_echo_pkg holds:
  - typedef for element (logic [ELEM_W-1:0]);
  - the entry struct {reverse, vector};
  - function reverse_elems(vector).
- One sub-module, ivector_echo_fifo: generic registered FIFO (WIDTH, DEPTH) with enq/deq ENA/RDY, count output, synchronous active-high reset.
- The top instantiates it with WIDTH=VEC_W+1 and applies the transform on its output.

Test Plan:
- Reset then idle -> request$say__RDY=1, ind$heard__ENA=0, occupancy=0 on the first post-reset cycle.
- Enqueue v with element i = i+1 (reverse=0), ind$heard__RDY=1 -> next cycle ind$heard__ENA=1 with identical v; dequeued that cycle; occupancy returns to 0.
- Enqueue the same v with reverse=1 -> element 0 = 22, element 21 = 1 (default params).
- Hold ind$heard__RDY=0 and enqueue 4 vectors -> occupancy=4, request$say__RDY=0. A fifth ENA is not accepted (assertion fires). Release RDY -> the 4 vectors emerge in order on consecutive cycles.
- With count=2, enq and deq in the same cycle for 10 cycles -> occupancy stays 2; order is preserved across pointer wrap.
- Assert RST with 3 entries held -> next cycle ind$heard__ENA=0, occupancy=0; stats counters =0 when IVECTOR_ECHO_STATS_EN is defined.
